regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  32x32 integer register file answering the decoder's two read requests (re/raddr -> rdata).
//  Accepts one write-back per cycle.
//  Keeps a per-register pending-write scoreboard so the decoder can detect RAW hazards and stall.
//  Sits between the ID stage (read ports, issue port) and the WB stage (write port).
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    5   register index width (2**ADDR_W registers; index 0 is hardwired x0)
//  MAX_PEND  3   max in-flight writes tracked per register (counter width = clog2(MAX_PEND+1))
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       asynchronous, active-low reset
//  re1_i           in   1       read port 1 enable
//  raddr1_i        in   ADDR_W  read port 1 index
//  rdata1_o        out  DATA_W  read port 1 data
//  busy1_o         out  1       port 1 operand has an outstanding write (stall)
//  re2_i           in   1       read port 2 enable
//  raddr2_i        in   ADDR_W  read port 2 index
//  rdata2_o        out  DATA_W  read port 2 data
//  busy2_o         out  1       port 2 operand has an outstanding write (stall)
//  issue_i         in   1       ID issues an instruction that will write issue_waddr_i
//  issue_waddr_i   in   ADDR_W  destination of the issued instruction
//  issue_ready_o   out  1       an issue to issue_waddr_i is accepted this cycle
//  we_i            in   1       WB write enable
//  waddr_i         in   ADDR_W  WB destination
//  wdata_i         in   DATA_W  WB data
//  pend_err_o      out  1       sticky: a write-back arrived for a register with zero pending count
// BEHAVIOUR
//  Reset (rst==0, async): all registers <= 0; all pending counters <= 0; pend_err_o <= 0.
//   While rst==0: rdata*_o = 0, busy*_o = 0, issue_ready_o = 0.
//  Write: on posedge clk, if we_i && waddr_i!=0, then reg[waddr_i] <= wdata_i.
//   Writes to x0 are dropped.
//  Read (combinational, 0-cycle latency), per port n:
//   - re_n==0 -> rdata=0, busy=0.
//   - raddr_n==0 -> rdata=0, busy=0.
//   - we_i && waddr_i==raddr_n -> rdata=wdata_i (write-through bypass).
//   - otherwise rdata=reg[raddr_n].
//  Busy, per port n: busy_n = re_n && raddr_n!=0 && cnt[raddr_n]!=0,
//   except busy_n=0 when we_i && waddr_i==raddr_n && cnt[raddr_n]==1 (last pending write is being bypassed).
//  Issue handshake: issue_ready_o = (issue_waddr_i==0) || cnt[issue_waddr_i] < MAX_PEND.
//   - An issue is accepted when issue_i && issue_ready_o.
//   - ID holds issue_i and issue_waddr_i stable until accepted.
//   - An accepted issue to x0 has no effect on the counters.
//  Counter update, on posedge clk, per register r!=0:
//   - inc = accepted issue to r; dec = we_i && waddr_i==r && cnt[r]!=0.
//   - inc&&!dec: cnt+1; dec&&!inc: cnt-1; both or neither: unchanged.
//   - Issue and write-back to the same register in one cycle: net 0.
//   - The bypass/busy decision uses the pre-update count.
//  Underflow: we_i to r!=0 with cnt[r]==0 still writes the data.
//   - The counter stays 0.
//   - pend_err_o <= 1 and holds until reset.
//  Overflow: impossible, because issue_ready_o blocks it. cnt never exceeds MAX_PEND.
//  Both read ports may address the same register. Each port is resolved independently and identically.
//  Reset mid-operation: all pending counts are discarded. After release, every register reads 0 and none is busy.
// TESTING
//  1. Reset release, read x5 on both ports -> rdata1=rdata2=0, busy=0, issue_ready=1.
//  2. we_i=1, waddr=3, wdata=0x1234 with the same cycle raddr1=3 -> rdata1=0x1234 (bypass).
//     Next cycle, with we_i=0 -> rdata1=0x1234 from the array.
//  3. Issue to x7, then read x7 -> busy1=1.
//     WB to x7 with wdata=0xA5 in the same cycle as the read -> busy1=0, rdata1=0xA5.
//     Next cycle: cnt[7]==0.
//  4. Three issues to x9 -> issue_ready_o=0 for x9; a 4th issue is held.
//     One WB to x9 -> issue_ready_o=1; the held issue is accepted; cnt stays 3.
//  5. WB to x0 with 0xFFFF_FFFF; issue to x0 -> x0 reads 0, never busy, issue_ready_o=1.
//     WB to x4 with cnt=0 -> x4 written, pend_err_o=1 sticky.
//  6. Issue to x2 and WB to x2 in the same cycle with cnt[2]=1 -> cnt[2] stays 1.
//     Then assert rst mid-cycle -> outputs go to 0 immediately; after release, x2 reads 0 and is not busy.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// ID/WB-facing bundle of the register file: two read ports, the issue handshake and the write-back port.
// The master side (decoder/WB) drives requests; the slave side (register file) answers combinationally.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              busy1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic              busy2_o;
  logic              issue_i;
  logic [ADDR_W-1:0] issue_waddr_i;
  logic              issue_ready_o;
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              pend_err_o;

  modport master (
    output re1_i, raddr1_i, re2_i, raddr2_i, issue_i, issue_waddr_i, we_i, waddr_i, wdata_i,
    input  rdata1_o, busy1_o, rdata2_o, busy2_o, issue_ready_o, pend_err_o
  );

  modport slave (
    input  re1_i, raddr1_i, re2_i, raddr2_i, issue_i, issue_waddr_i, we_i, waddr_i, wdata_i,
    output rdata1_o, busy1_o, rdata2_o, busy2_o, issue_ready_o, pend_err_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R1W register file with per-register pending-write counters for RAW stall detection.
// Reads are 0-cycle with WB bypass; issue is back-pressured by issue_ready_o once a register has MAX_PEND writes in flight.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_PEND = 3
) (
  input logic              clk,
  input logic              rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic              pend_err;

  logic [1:0]             re;
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             busy;

  logic            wb_nz;
  logic            issue_ready;
  logic            issue_acc;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  assign re[0]    = bus.re1_i;
  assign re[1]    = bus.re2_i;
  assign raddr[0] = bus.raddr1_i;
  assign raddr[1] = bus.raddr2_i;

  assign wb_nz = bus.we_i && (bus.waddr_i != '0);

  // Both ports resolve identically; the bypass and busy decision use the pre-update count.
  always_comb begin
    rdata = '0;
    busy  = '0;
    for (int p = 0; p < 2; p++) begin
      if (rst && re[p] && (raddr[p] != '0)) begin
        if (bus.we_i && (bus.waddr_i == raddr[p])) begin
          rdata[p] = bus.wdata_i;
        end else begin
          rdata[p] = regs[raddr[p]];
        end
        busy[p] = (cnt[raddr[p]] != '0) &&
                  !(bus.we_i && (bus.waddr_i == raddr[p]) && (cnt[raddr[p]] == CNT_W'(1)));
      end
    end
  end

  assign issue_ready = rst && ((bus.issue_waddr_i == '0) ||
                               (cnt[bus.issue_waddr_i] < CNT_W'(MAX_PEND)));
  assign issue_acc   = bus.issue_i && issue_ready && (bus.issue_waddr_i != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_acc) begin
      inc_vec[bus.issue_waddr_i] = 1'b1;
    end
    if (wb_nz && (cnt[bus.waddr_i] != '0)) begin
      dec_vec[bus.waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_nz) begin
      regs[bus.waddr_i] <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      pend_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      // A write-back nobody announced: keep the data, flag the decoder bug until reset.
      if (wb_nz && (cnt[bus.waddr_i] == '0)) begin
        pend_err <= 1'b1;
      end
    end
  end

  assign bus.rdata1_o      = rdata[0];
  assign bus.busy1_o       = busy[0];
  assign bus.rdata2_o      = rdata[1];
  assign bus.busy2_o       = busy[1];
  assign bus.issue_ready_o = issue_ready;
  assign bus.pend_err_o    = pend_err;
endmodule
